// File: rtl/xxx_frame_buf_if.sv
// Sample-in / frame-out bundle of the ping-pong frame buffer.
// slave is the buffer's own view; master is the upstream/FFT-side view used by a driver.
interface xxx_frame_buf_if #(
   parameter int DATA_W = 16
) ();
   logic              xxx_dt_valid_i;
   logic              smp_valid_i;
   logic [DATA_W-1:0] smp_data_i;
   logic              out_valid_o;
   logic              out_ready_i;
   logic [DATA_W-1:0] out_data_o;
   logic              out_sop_o;
   logic              out_eop_o;
   logic              ovf_o;
   logic              ovf_sticky_o;

   modport slave (
      input  xxx_dt_valid_i, smp_valid_i, smp_data_i, out_ready_i,
      output out_valid_o, out_data_o, out_sop_o, out_eop_o, ovf_o, ovf_sticky_o
   );

   modport master (
      output xxx_dt_valid_i, smp_valid_i, smp_data_i, out_ready_i,
      input  out_valid_o, out_data_o, out_sop_o, out_eop_o, ovf_o, ovf_sticky_o
   );
endinterface

// File: rtl/xxx_frame_buf.sv
// Two-bank ping-pong frame buffer: packs gated samples into FRAME_LEN frames and
// streams each full frame with sop/eop. Output handshake: a beat moves on out_valid_o & out_ready_i.
module xxx_frame_buf #(
   parameter int FRAME_LEN = 16,
   parameter int DATA_W    = 16
) (
   input  logic                clk_cg_i,
   input  logic                rst_i,
   xxx_frame_buf_if.slave      bus,
   output logic                dbg_rd_state_o
);
   localparam int IDX_W = $clog2(FRAME_LEN);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_LEN - 1);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } rd_state_e;

   rd_state_e         state_q, state_d;
   logic              wr_bank_q, wr_bank_d;
   logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
   logic              rd_bank_q, rd_bank_d;
   logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
   logic [1:0]        full_q, full_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_sop_q, out_sop_d;
   logic              out_eop_q, out_eop_d;
   logic              ovf_q, ovf_d;
   logic              ovf_sticky_q, ovf_sticky_d;

   logic [DATA_W-1:0] bank_q [2][FRAME_LEN];
   logic              wr_en;
   logic [1:0]        set_full, clr_full;
   logic              smp_req, xfer;
   logic [IDX_W-1:0]  rd_idx_nxt;

   assign smp_req    = bus.smp_valid_i & bus.xxx_dt_valid_i;
   assign xfer       = out_valid_q & bus.out_ready_i;
   assign rd_idx_nxt = rd_idx_q + IDX_W'(1);

   // Write side: the full flag is looked at pre-edge, so a bank freed this cycle still drops.
   always_comb begin
      wr_bank_d    = wr_bank_q;
      wr_idx_d     = wr_idx_q;
      ovf_d        = 1'b0;
      ovf_sticky_d = ovf_sticky_q;
      wr_en        = 1'b0;
      set_full     = 2'b00;
      if (!bus.xxx_dt_valid_i) begin
         wr_idx_d = '0;
      end else if (smp_req) begin
         if (full_q[wr_bank_q]) begin
            ovf_d        = 1'b1;
            ovf_sticky_d = 1'b1;
         end else begin
            wr_en = 1'b1;
            if (wr_idx_q == LAST) begin
               wr_idx_d            = '0;
               wr_bank_d           = ~wr_bank_q;
               set_full[wr_bank_q] = 1'b1;
            end else begin
               wr_idx_d = wr_idx_q + IDX_W'(1);
            end
         end
      end
   end

   // Read side: outputs are registered, so the next word is fetched as the current one transfers.
   always_comb begin
      state_d     = state_q;
      rd_bank_d   = rd_bank_q;
      rd_idx_d    = rd_idx_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sop_d   = out_sop_q;
      out_eop_d   = out_eop_q;
      clr_full    = 2'b00;
      case (state_q)
         ST_IDLE: begin
            if (full_q[rd_bank_q]) begin
               state_d     = ST_STREAM;
               rd_idx_d    = '0;
               out_valid_d = 1'b1;
               out_data_d  = bank_q[rd_bank_q][0];
               out_sop_d   = 1'b1;
               out_eop_d   = 1'b0;
            end
         end
         ST_STREAM: begin
            if (xfer) begin
               if (rd_idx_q == LAST) begin
                  clr_full[rd_bank_q] = 1'b1;
                  rd_bank_d           = ~rd_bank_q;
                  rd_idx_d            = '0;
                  if (full_q[~rd_bank_q]) begin
                     out_data_d = bank_q[~rd_bank_q][0];
                     out_sop_d  = 1'b1;
                     out_eop_d  = 1'b0;
                  end else begin
                     state_d     = ST_IDLE;
                     out_valid_d = 1'b0;
                     out_sop_d   = 1'b0;
                     out_eop_d   = 1'b0;
                  end
               end else begin
                  rd_idx_d   = rd_idx_nxt;
                  out_data_d = bank_q[rd_bank_q][rd_idx_nxt];
                  out_sop_d  = 1'b0;
                  out_eop_d  = (rd_idx_nxt == LAST);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      full_d = (full_q | set_full) & ~clr_full;
   end

   always_ff @(posedge clk_cg_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         wr_bank_q    <= 1'b0;
         wr_idx_q     <= '0;
         rd_bank_q    <= 1'b0;
         rd_idx_q     <= '0;
         full_q       <= 2'b00;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_sop_q    <= 1'b0;
         out_eop_q    <= 1'b0;
         ovf_q        <= 1'b0;
         ovf_sticky_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_bank_q    <= wr_bank_d;
         wr_idx_q     <= wr_idx_d;
         rd_bank_q    <= rd_bank_d;
         rd_idx_q     <= rd_idx_d;
         full_q       <= full_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_sop_q    <= out_sop_d;
         out_eop_q    <= out_eop_d;
         ovf_q        <= ovf_d;
         ovf_sticky_q <= ovf_sticky_d;
      end
   end

   // Sample storage carries no reset; stale contents are never read before a full flag is set.
   always_ff @(posedge clk_cg_i) begin
      if (wr_en) begin
         bank_q[wr_bank_q][wr_idx_q] <= bus.smp_data_i;
      end
   end

   assign bus.out_valid_o  = out_valid_q;
   assign bus.out_data_o   = out_data_q;
   assign bus.out_sop_o    = out_sop_q;
   assign bus.out_eop_o    = out_eop_q;
   assign bus.ovf_o        = ovf_q;
   assign bus.ovf_sticky_o = ovf_sticky_q;
   assign dbg_rd_state_o   = state_q;
endmodule
